// File: rtl/dft_blk_if.sv
// DFT output sample stream into the block sink.
// Master drives samples plus point count; slave receives.
interface dft_blk_if #(
  parameter int DW = 16,
  parameter int SW = 11
);
  logic [SW-1:0] dft_size;
  logic          din_vld;
  logic          din_sop;
  logic [DW-1:0] din_re;
  logic [DW-1:0] din_im;

  modport master (
    output dft_size, din_vld, din_sop,
    output din_re, din_im
  );

  modport slave (
    input dft_size, din_vld, din_sop,
    input din_re, din_im
  );
endinterface

// File: rtl/dft_blk_sink.sv
// Receive-side DFT block framer: per-block checksum,
// peak magnitude and sticky framing errors.
module dft_blk_sink #(
  parameter int DW       = 16,
  parameter int SW       = 11,
  parameter int CW       = 32,
  parameter int MIN_SIZE = 12,
  parameter int MAX_SIZE = 1200
) (
  input  logic          clk,
  input  logic          rst,
  dft_blk_if.slave      s,
  output logic          blk_done,
  output logic [15:0]   blk_cnt,
  output logic [CW-1:0] blk_csum,
  output logic [DW-1:0] blk_peak,
  output logic          err_short,
  output logic          err_orph,
  output logic          err_size,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    REPORT
  } state_t;

  localparam logic [SW-1:0] MIN_S = SW'(MIN_SIZE);
  localparam logic [SW-1:0] MAX_S = SW'(MAX_SIZE);
  localparam logic [DW-1:0] MAXP  = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MOSTN = {1'b1, {(DW-1){1'b0}}};

  // |x| saturating the most-negative code
  function automatic logic [DW-1:0] mag(
    input logic [DW-1:0] x
  );
    logic [DW-1:0] r;
    if (x == MOSTN)
      r = MAXP;
    else if (x[DW-1])
      r = ~x + 1'b1;
    else
      r = x;
    return r;
  endfunction

  function automatic logic [CW-1:0] sext(
    input logic [DW-1:0] x
  );
    return {{(CW-DW){x[DW-1]}}, x};
  endfunction

  state_t        state_q, state_d;
  logic [SW-1:0] size_q, size_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] csum_q, csum_d;
  logic [DW-1:0] peak_q, peak_d;
  logic [CW-1:0] blk_csum_q, blk_csum_d;
  logic [DW-1:0] blk_peak_q, blk_peak_d;
  logic [15:0]   blk_cnt_q, blk_cnt_d;
  logic          err_short_q, err_short_d;
  logic          err_orph_q, err_orph_d;
  logic          err_size_q, err_size_d;

  logic          start;
  logic          data;
  logic          legal;
  logic          last;
  logic [SW-1:0] cnt_inc;
  logic [DW-1:0] mag_re;
  logic [DW-1:0] mag_im;
  logic [DW-1:0] smp_peak;
  logic [DW-1:0] acc_peak;
  logic [CW-1:0] smp_sum;
  logic [CW-1:0] acc_sum;

  always_comb begin
    start    = s.din_vld & s.din_sop;
    data     = s.din_vld & ~s.din_sop;
    legal    = (s.dft_size >= MIN_S) &&
               (s.dft_size <= MAX_S);
    cnt_inc  = cnt_q + SW'(1);
    last     = (cnt_inc == size_q);
    mag_re   = mag(s.din_re);
    mag_im   = mag(s.din_im);
    smp_peak = (mag_re > mag_im) ? mag_re : mag_im;
    acc_peak = (peak_q > smp_peak) ? peak_q : smp_peak;
    smp_sum  = sext(s.din_re) + sext(s.din_im);
    acc_sum  = csum_q + smp_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      size_q      <= '0;
      cnt_q       <= '0;
      csum_q      <= '0;
      peak_q      <= '0;
      blk_csum_q  <= '0;
      blk_peak_q  <= '0;
      blk_cnt_q   <= '0;
      err_short_q <= 1'b0;
      err_orph_q  <= 1'b0;
      err_size_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      cnt_q       <= cnt_d;
      csum_q      <= csum_d;
      peak_q      <= peak_d;
      blk_csum_q  <= blk_csum_d;
      blk_peak_q  <= blk_peak_d;
      blk_cnt_q   <= blk_cnt_d;
      err_short_q <= err_short_d;
      err_orph_q  <= err_orph_d;
      err_size_q  <= err_size_d;
    end
  end

  // REPORT behaves like IDLE for incoming samples
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, REPORT: begin
        state_d = (start && legal) ? COLLECT : IDLE;
      end
      COLLECT: begin
        if (start)
          state_d = legal ? COLLECT : IDLE;
        else if (data && last)
          state_d = REPORT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    size_d      = size_q;
    cnt_d       = cnt_q;
    csum_d      = csum_q;
    peak_d      = peak_q;
    blk_csum_d  = blk_csum_q;
    blk_peak_d  = blk_peak_q;
    blk_cnt_d   = blk_cnt_q;
    err_short_d = err_short_q;
    err_orph_d  = err_orph_q;
    err_size_d  = err_size_q;
    if (start) begin
      if (state_q == COLLECT)
        err_short_d = 1'b1;
      if (legal) begin
        size_d = s.dft_size;
        cnt_d  = SW'(1);
        csum_d = smp_sum;
        peak_d = smp_peak;
      end else begin
        err_size_d = 1'b1;
      end
    end else if (data) begin
      if (state_q == COLLECT) begin
        cnt_d  = cnt_inc;
        csum_d = acc_sum;
        peak_d = acc_peak;
        if (last) begin
          blk_csum_d = acc_sum;
          blk_peak_d = acc_peak;
          blk_cnt_d  = blk_cnt_q + 16'd1;
        end
      end else begin
        err_orph_d = 1'b1;
      end
    end
  end

  always_comb begin
    blk_done  = (state_q == REPORT);
    busy      = (state_q == COLLECT);
    blk_cnt   = blk_cnt_q;
    blk_csum  = blk_csum_q;
    blk_peak  = blk_peak_q;
    err_short = err_short_q;
    err_orph  = err_orph_q;
    err_size  = err_size_q;
  end

endmodule

// File: tb/tb_dft_blk_sink.sv
// Bench for dft_blk_sink: directed scenarios plus
// randomized blocks against a queue-based block model.
module tb_dft_blk_sink;
  localparam int DW = 16;
  localparam int SW = 11;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          blk_done;
  logic [15:0]   blk_cnt;
  logic [CW-1:0] blk_csum;
  logic [DW-1:0] blk_peak;
  logic          err_short;
  logic          err_orph;
  logic          err_size;
  logic          busy;

  dft_blk_if #(.DW(DW), .SW(SW)) bus ();

  dft_blk_sink #(
    .DW(DW), .SW(SW), .CW(CW),
    .MIN_SIZE(12), .MAX_SIZE(1200)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s(bus),
    .blk_done(blk_done),
    .blk_cnt(blk_cnt),
    .blk_csum(blk_csum),
    .blk_peak(blk_peak),
    .err_short(err_short),
    .err_orph(err_orph),
    .err_size(err_size),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] csum;
    logic [15:0] peak;
    logic [15:0] cnt;
    int          cyc;
  } rep_t;

  rep_t act_q[$];
  rep_t exp_q[$];

  always @(negedge clk)
    if (blk_done === 1'b1)
      act_q.push_back('{blk_csum, blk_peak, blk_cnt, cyc});

  // reference model: whole-block view
  bit m_act;
  int m_len;
  int m_re[$];
  int m_im[$];
  int m_blocks;
  bit m_eshort, m_eorph, m_esize;

  function automatic int absx(int x);
    if (x == -32768) return 32767;
    return (x < 0) ? -x : x;
  endfunction

  function automatic int rnd();
    if ($urandom_range(0, 15) == 0) return -32768;
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic model_step(bit v, bit sp, int size,
                            int re, int im);
    longint sum;
    int pk;
    logic [63:0] s64;
    if (v && sp) begin
      if (m_act) m_eshort = 1;
      if (size >= 12 && size <= 1200) begin
        m_act = 1;
        m_len = size;
        m_re = {re};
        m_im = {im};
      end else begin
        m_esize = 1;
        m_act = 0;
      end
    end else if (v) begin
      if (!m_act) m_eorph = 1;
      else begin
        m_re.push_back(re);
        m_im.push_back(im);
        if (m_re.size() == m_len) begin
          sum = 0;
          pk = 0;
          foreach (m_re[i]) begin
            sum += longint'(m_re[i]) + longint'(m_im[i]);
            if (absx(m_re[i]) > pk) pk = absx(m_re[i]);
            if (absx(m_im[i]) > pk) pk = absx(m_im[i]);
          end
          m_blocks++;
          s64 = sum;
          exp_q.push_back('{s64[31:0], 16'(pk),
                            16'(m_blocks), cyc + 1});
          m_act = 0;
        end
      end
    end
  endtask

  task automatic drive(bit v, bit sp, int size,
                       int re, int im);
    bus.din_vld  = v;
    bus.din_sop  = sp;
    bus.dft_size = size[SW-1:0];
    bus.din_re   = re[DW-1:0];
    bus.din_im   = im[DW-1:0];
    model_step(v, sp, size, re, im);
    @(posedge clk);
    #1;
    bus.din_vld = 1'b0;
    bus.din_sop = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.din_vld = 1'b0;
    bus.din_sop = 1'b0;
    bus.dft_size = '0;
    bus.din_re = '0;
    bus.din_im = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_act = 0;
    m_blocks = 0;
    m_eshort = 0;
    m_eorph = 0;
    m_esize = 0;
    m_re = {};
    m_im = {};
    act_q = {};
    exp_q = {};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.din_vld = 1'b0;
    bus.din_sop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({blk_done, blk_cnt, blk_csum, blk_peak} !== '0)
      $display("FAIL reset_data: got %0h/%0h/%0h/%0h want 0",
               blk_done, blk_cnt, blk_csum, blk_peak);
    if ({blk_done, blk_cnt, blk_csum, blk_peak} !== '0)
      errors++;
    checks++;
    if ({err_short, err_orph, err_size, busy} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000",
               {err_short, err_orph, err_size, busy});
    end
    do_reset();
  endtask

  task automatic test_basic();
    int last_cyc;
    do_reset();
    drive(1, 1, 12, 0, 0);
    for (int k = 1; k < 12; k++) begin
      if (k == 5) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL basic_busy: got %b want 1", busy);
        end
      end
      last_cyc = cyc;
      drive(1, 0, 12, k, -k);
    end
    idle(3);
    checks++;
    if (act_q.size() !== 1) begin
      errors++;
      $display("FAIL basic_nrep: got %0d want 1",
               act_q.size());
    end else begin
      checks++;
      if (act_q[0].csum !== 32'd0 ||
          act_q[0].peak !== 16'd11 ||
          act_q[0].cnt !== 16'd1) begin
        errors++;
        $display("FAIL basic_rep: got %0h/%0d/%0d want 0/11/1",
                 act_q[0].csum, act_q[0].peak, act_q[0].cnt);
      end
      checks++;
      if (act_q[0].cyc !== last_cyc + 1) begin
        errors++;
        $display("FAIL basic_lat: got %0d want %0d",
                 act_q[0].cyc, last_cyc + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 1200; i++)
        drive(1, i == 0, 1200, 1, 0);
    idle(3);
    checks++;
    if (act_q.size() !== 2) begin
      errors++;
      $display("FAIL b2b_nrep: got %0d want 2", act_q.size());
    end else begin
      checks++;
      if (act_q[1].cyc - act_q[0].cyc !== 1200) begin
        errors++;
        $display("FAIL b2b_gap: got %0d want 1200",
                 act_q[1].cyc - act_q[0].cyc);
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (act_q[i].csum !== 32'd1200 ||
            act_q[i].cnt !== 16'(i + 1)) begin
          errors++;
          $display("FAIL b2b_rep%0d: got %0d/%0d want 1200/%0d",
                   i, act_q[i].csum, act_q[i].cnt, i + 1);
        end
      end
    end
    checks++;
    if ({err_short, err_orph, err_size} !== 3'b0) begin
      errors++;
      $display("FAIL b2b_err: got %b want 000",
               {err_short, err_orph, err_size});
    end
  endtask

  task automatic test_short();
    do_reset();
    for (int i = 0; i < 10; i++) drive(1, i == 0, 24, 9, 9);
    for (int i = 0; i < 12; i++) drive(1, i == 0, 12, 2, 3);
    idle(3);
    checks++;
    if (err_short !== 1'b1) begin
      errors++;
      $display("FAIL short_flag: got %b want 1", err_short);
    end
    checks++;
    if (act_q.size() !== 1) begin
      errors++;
      $display("FAIL short_nrep: got %0d want 1", act_q.size());
    end else begin
      checks++;
      if (act_q[0].csum !== 32'd60 ||
          act_q[0].peak !== 16'd3 ||
          act_q[0].cnt !== 16'd1) begin
        errors++;
        $display("FAIL short_rep: got %0d/%0d/%0d want 60/3/1",
                 act_q[0].csum, act_q[0].peak, act_q[0].cnt);
      end
    end
  endtask

  task automatic test_orph_size();
    do_reset();
    for (int i = 0; i < 3; i++) drive(1, 0, 12, 5, 5);
    idle(1);
    checks++;
    if ({err_orph, err_size} !== 2'b10) begin
      errors++;
      $display("FAIL orph_flag: got %b want 10",
               {err_orph, err_size});
    end
    drive(1, 1, 11, 1, 1);
    idle(1);
    checks++;
    if (err_size !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL size11: got %b%b want 10",
               err_size, busy);
    end
    do_reset();
    drive(1, 1, 1201, 1, 1);
    drive(1, 1, 1, 1, 1);
    idle(2);
    checks++;
    if ({err_size, err_orph, busy} !== 3'b100) begin
      errors++;
      $display("FAIL size1201: got %b want 100",
               {err_size, err_orph, busy});
    end
    checks++;
    if (act_q.size() !== 0) begin
      errors++;
      $display("FAIL size_nrep: got %0d want 0", act_q.size());
    end
  endtask

  task automatic test_neg();
    do_reset();
    for (int i = 0; i < 12; i++)
      drive(1, i == 0, 12, (i == 4) ? -32768 : 0, 0);
    idle(3);
    checks++;
    if (act_q.size() !== 1) begin
      errors++;
      $display("FAIL neg_nrep: got %0d want 1", act_q.size());
    end else begin
      checks++;
      if (act_q[0].peak !== 16'd32767 ||
          act_q[0].csum !== 32'hFFFF8000) begin
        errors++;
        $display("FAIL neg_rep: got %0h/%0h want 7fff/ffff8000",
                 act_q[0].peak, act_q[0].csum);
      end
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    for (int i = 0; i < 5; i++) drive(1, i == 0, 12, 7, 7);
    rst = 1'b1;
    bus.din_vld = 1'b1;
    bus.din_re = 16'd7;
    @(posedge clk);
    #1;
    bus.din_vld = 1'b0;
    checks++;
    if ({blk_done, blk_cnt, blk_csum, blk_peak, err_short,
         err_orph, err_size, busy} !== '0) begin
      errors++;
      $display("FAIL rstmid_zero: got %b%0h%0h%0h%b%b%b%b",
               blk_done, blk_cnt, blk_csum, blk_peak,
               err_short, err_orph, err_size, busy);
    end
    do_reset();
    for (int k = 0; k < 12; k++) drive(1, k == 0, 12, k, 0);
    idle(3);
    checks++;
    if (act_q.size() !== 1) begin
      errors++;
      $display("FAIL rstmid_nrep: got %0d want 1", act_q.size());
    end else begin
      checks++;
      if (act_q[0].cnt !== 16'd1 ||
          act_q[0].csum !== 32'd66 ||
          act_q[0].peak !== 16'd11) begin
        errors++;
        $display("FAIL rstmid_rep: got %0d/%0d/%0d want 1/66/11",
                 act_q[0].cnt, act_q[0].csum, act_q[0].peak);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int b = 0; b < 12; b++) begin
      int n;
      int len;
      n = $urandom_range(12, 40);
      len = ($urandom_range(0, 3) == 0) ?
            $urandom_range(1, n - 1) : n;
      if ($urandom_range(0, 5) == 0) drive(1, 0, n, 7, 7);
      for (int i = 0; i < len; i++) begin
        while ($urandom_range(0, 3) == 0) drive(0, 0, 0, 0, 0);
        drive(1, i == 0,
              (i == 0) ? n : int'($urandom_range(0, 2047)),
              rnd(), rnd());
      end
    end
    idle(3);
    checks++;
    if (act_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL rand_nrep: got %0d want %0d",
               act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      checks++;
      if (act_q[i].csum !== exp_q[i].csum ||
          act_q[i].peak !== exp_q[i].peak ||
          act_q[i].cnt !== exp_q[i].cnt ||
          act_q[i].cyc !== exp_q[i].cyc) begin
        errors++;
        $display("FAIL rand_rep%0d: got %0h/%0h/%0d@%0d want %0h/%0h/%0d@%0d",
                 i, act_q[i].csum, act_q[i].peak, act_q[i].cnt,
                 act_q[i].cyc, exp_q[i].csum, exp_q[i].peak,
                 exp_q[i].cnt, exp_q[i].cyc);
      end
    end
    checks++;
    if ({err_short, err_orph, err_size} !==
        {m_eshort, m_eorph, m_esize}) begin
      errors++;
      $display("FAIL rand_err: got %b want %b",
               {err_short, err_orph, err_size},
               {m_eshort, m_eorph, m_esize});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_short();
    test_orph_size();
    test_neg();
    test_rst_mid();
    for (int r = 0; r < 4; r++) test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
